vending_machine_sequencer: RTL
==============================

// Module: vending_machine_sequencer
// PURPOSE
//   Sequencing FSM for the vending machine. Drives state code S2,S1,S0 into
//   vending_machine_control_logic, which decodes A (accept coin) and P (release product).
//   Accumulates coin credit, runs the product-release handshake, returns change or refund
//   one nickel at a time, and counts completed sales.
// PARAMETERS
//   PRICE     35  product price in cents; must be a multiple of 5, >= 5
//   CREDIT_W  8   credit register width; PRICE+25 < 2**CREDIT_W required
//   CNT_W     16  sale counter width
// PORTS
//   clk           in   1         clock, all logic on posedge
//   rst_n         in   1         synchronous active-low reset
//   coin_valid    in   1         coin presented
//   coin_type     in   2         00=nickel(5) 01=dime(10) 10=quarter(25) 11=invalid
//   coin_ready    out  1         coin accepted this cycle if coin_valid (= decoded A)
//   coin_reject   out  1         1-cycle pulse: invalid coin_type handshaked
//   cancel        in   1         request refund of current credit
//   vend_valid    out  1         release product (= decoded P)
//   vend_ready    in   1         mechanism took product
//   change_valid  out  1         one nickel of change/refund offered
//   change_ready  in   1         nickel taken
//   state         out  3         {S2,S1,S0} state code
//   credit        out  CREDIT_W  current credit in cents
//   refunding     out  1         high in REFUND
//   sale_count    out  CNT_W     completed vends, wraps at 2**CNT_W
// BEHAVIOUR
//   Clock is clk. Reset is synchronous, active-low on rst_n. On rst_n=0 at posedge:
//   state=IDLE, credit=0, sale_count=0, coin_reject=0. While rst_n=0, coin_ready=0.
//   State encoding gives the required A/P decode:
//     IDLE=011 (A1 P0), COLLECT=111 (A1 P0), DISPENSE=100 (A0 P1),
//     CHANGE=000 (A0 P0), REFUND=110 (A0 P0).
//   Outputs: coin_ready=A, vend_valid=P. change_valid=1 only in CHANGE/REFUND with credit>0.
//   Coin handshake = coin_valid & coin_ready.
//     Valid coin: credit+=value, visible next cycle.
//     Type 11: credit unchanged, coin_reject=1 next cycle.
//   IDLE/COLLECT, evaluated with the post-coin credit c:
//     - If cancel and c>0: go to REFUND. A coin accepted in the same cycle is included.
//     - Else if c>=PRICE: go to DISPENSE. vend_valid is high 1 cycle after the final coin.
//     - Else if c>0: go to COLLECT.
//     - Else: stay in IDLE. cancel is ignored with zero credit.
//   DISPENSE: hold vend_valid until vend_ready. On the handshake: credit-=PRICE,
//     sale_count++, then go to CHANGE if the remainder >0, else IDLE. cancel is ignored.
//   CHANGE/REFUND: each change_ready handshake subtracts 5. When credit reaches 0,
//     go to IDLE the next cycle. change_valid stays asserted across change_ready stalls.
//   Illegal codes 001/010/101: go to REFUND if credit>0, else IDLE, next cycle.
//   Reset mid-operation discards credit. No change or refund is issued.
//   Credit never overflows: coins accepted only while credit<PRICE, max PRICE+20.
// STRUCTURE
//   vending_pkg: state_e (3-bit codes above), coin_e, NICKEL/DIME/QUARTER constants,
//     coin_value() function.
//   Sub-module: vending_machine_control_logic (existing) decodes state into A/P.
//   Sequencer owns the state register, credit register, sale counter and coin_reject flop.
// TESTING (PRICE=35)
//   Reset 2 cycles, release -> state=011, credit=0, coin_ready=1, vend_valid=0,
//     change_valid=0.
//   Quarter then dime -> state=100, credit=35, vend_valid=1. vend_ready held 3 cycles
//     -> IDLE, credit=0, sale_count=1.
//   Two quarters -> credit=50, DISPENSE. After vend: CHANGE, credit=15. Three nickel
//     handshakes with a 2-cycle change_ready stall -> IDLE after the 3rd.
//   coin_type=11 in IDLE -> coin_reject pulse 1 cycle, credit=0, state stays 011.
//     Then a dime -> COLLECT, credit=10.
//   Dime, then cancel with a nickel in the same cycle -> REFUND (110), credit=15,
//     3 nickel handshakes -> IDLE. cancel in IDLE with credit 0 -> no change.
//   Force state=101 with credit=20 -> REFUND next cycle. rst_n low during DISPENSE
//     -> IDLE, credit=0, sale_count unchanged from 0.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared types and coin helpers for the vending machine sequencer.
// State codes are chosen so A/P fall straight out of the three state bits.
package vending_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'b011,
        ST_COLLECT  = 3'b111,
        ST_DISPENSE = 3'b100,
        ST_CHANGE   = 3'b000,
        ST_REFUND   = 3'b110
    } state_e;

    typedef enum logic [1:0] {
        COIN_NICKEL  = 2'b00,
        COIN_DIME    = 2'b01,
        COIN_QUARTER = 2'b10,
        COIN_INVALID = 2'b11
    } coin_e;

    localparam logic [4:0] NICKEL  = 5'd5;
    localparam logic [4:0] DIME    = 5'd10;
    localparam logic [4:0] QUARTER = 5'd25;

    function automatic logic [4:0] coin_value(input coin_e kind);
        logic [4:0] v;
        v = '0;
        unique case (kind)
            COIN_NICKEL:  v = NICKEL;
            COIN_DIME:    v = DIME;
            COIN_QUARTER: v = QUARTER;
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vending_machine_control_logic.sv
// Decodes the sequencer state code into accept-coin (A) and release-product (P).
// A is high for x11 codes, P only for 100.
module vending_machine_control_logic (
    input  logic s2,
    input  logic s1,
    input  logic s0,
    output logic a,
    output logic p
);

    assign a = s1 & s0;
    assign p = s2 & ~s1 & ~s0;

endmodule

// File: rtl/vending_machine_sequencer.sv
// Vending machine sequencer: coin credit, vend handshake, nickel change/refund,
// and a wrapping count of completed sales.
module vending_machine_sequencer
    import vending_pkg::*;
#(
    parameter int PRICE    = 35,
    parameter int CREDIT_W = 8,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_type,
    output logic                coin_ready,
    output logic                coin_reject,
    input  logic                cancel,
    output logic                vend_valid,
    input  logic                vend_ready,
    output logic                change_valid,
    input  logic                change_ready,
    output logic [2:0]          state,
    output logic [CREDIT_W-1:0] credit,
    output logic                refunding,
    output logic [CNT_W-1:0]    sale_count
);

    localparam logic [CREDIT_W-1:0] PRICE_C  = CREDIT_W'(PRICE);
    localparam logic [CREDIT_W-1:0] NICKEL_C = CREDIT_W'(NICKEL);

    logic [2:0]          state_q;
    logic [CREDIT_W-1:0] credit_q;
    logic [CNT_W-1:0]    sale_q;
    logic                reject_q;

    logic                dec_a;
    logic                dec_p;
    logic                coin_hs;
    logic                coin_bad;
    logic [CREDIT_W-1:0] coin_amt;
    logic [CREDIT_W-1:0] post_coin;
    logic [CREDIT_W-1:0] remainder;

    vending_machine_control_logic u_ctrl (
        .s2 (state_q[2]),
        .s1 (state_q[1]),
        .s0 (state_q[0]),
        .a  (dec_a),
        .p  (dec_p)
    );

    assign coin_ready = dec_a & rst_n;
    assign coin_hs    = coin_valid & coin_ready;
    assign coin_bad   = coin_hs & (coin_e'(coin_type) == COIN_INVALID);
    assign coin_amt   = coin_hs ? CREDIT_W'(coin_value(coin_e'(coin_type)))
                                : '0;
    // Invalid coins contribute zero, so post_coin is safe to use unconditionally.
    assign post_coin  = credit_q + coin_amt;
    assign remainder  = credit_q - PRICE_C;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            sale_q   <= '0;
            reject_q <= 1'b0;
        end else begin
            reject_q <= coin_bad;
            unique case (state_q)
                ST_IDLE, ST_COLLECT: begin
                    credit_q <= post_coin;
                    if (cancel && post_coin != '0) begin
                        state_q <= ST_REFUND;
                    end else if (post_coin >= PRICE_C) begin
                        state_q <= ST_DISPENSE;
                    end else if (post_coin != '0) begin
                        state_q <= ST_COLLECT;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DISPENSE: begin
                    if (vend_ready) begin
                        credit_q <= remainder;
                        sale_q   <= sale_q + CNT_W'(1);
                        state_q  <= (remainder != '0) ? ST_CHANGE : ST_IDLE;
                    end
                end
                ST_CHANGE, ST_REFUND: begin
                    if (credit_q == '0) begin
                        state_q <= ST_IDLE;
                    end else if (change_ready) begin
                        credit_q <= credit_q - NICKEL_C;
                        if (credit_q == NICKEL_C) begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    // Unreachable codes: hand back whatever credit is held.
                    state_q <= (credit_q != '0) ? ST_REFUND : ST_IDLE;
                end
            endcase
        end
    end

    assign state        = state_q;
    assign credit       = credit_q;
    assign sale_count   = sale_q;
    assign coin_reject  = reject_q;
    assign vend_valid   = dec_p;
    assign refunding    = (state_q == ST_REFUND);
    assign change_valid = ((state_q == ST_CHANGE) || (state_q == ST_REFUND))
                          && (credit_q != '0);

endmodule
